onewire_master: RTL and testbench

- Bit-level 1-Wire bus master. It sits directly below the `temp` sensor controller and turns its reset, write-bit and read-bit commands into exactly timed bus slots on the `i_owr`/`o_owr` pin pair.
- Returns one response per command: presence flag or sampled bit, plus an error flag for a stuck-low bus (brownout or short detection).
- Timing is derived from a microsecond tick, so `temp` never handles bus timing itself.

---
 rtl/onewire_pkg.sv | 44 ++++
 rtl/onewire_tick.sv | 35 +++
 rtl/onewire_master.sv | 134 +++++++++++++
 tb/tb_onewire_master.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared encodings, FSM states and microsecond slot timing for the 1-Wire bit master.
package onewire_pkg;

    localparam int TUS_W = 10;

    localparam logic [1:0] CMD_RESET = 2'b00;
    localparam logic [1:0] CMD_W0    = 2'b01;
    localparam logic [1:0] CMD_W1    = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_WAIT,
        ST_RECOVER,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [TUS_W-1:0] T_RST_LOW = 10'd480;
    localparam logic [TUS_W-1:0] T_RST_SMP = 10'd550;
    localparam logic [TUS_W-1:0] T_RST_END = 10'd960;
    localparam logic [TUS_W-1:0] T_W0_LOW  = 10'd60;
    localparam logic [TUS_W-1:0] T_W1_LOW  = 10'd6;
    localparam logic [TUS_W-1:0] T_SMP     = 10'd15;
    localparam logic [TUS_W-1:0] T_SLOT    = 10'd70;

    function automatic logic [TUS_W-1:0] low_us(input logic [1:0] cmd);
        case (cmd)
            CMD_RESET: low_us = T_RST_LOW;
            CMD_W0:    low_us = T_W0_LOW;
            default:   low_us = T_W1_LOW;
        endcase
    endfunction

    function automatic logic [TUS_W-1:0] smp_us(input logic [1:0] cmd);
        smp_us = (cmd == CMD_RESET) ? T_RST_SMP : T_SMP;
    endfunction

    function automatic logic [TUS_W-1:0] end_us(input logic [1:0] cmd);
        end_us = (cmd == CMD_RESET) ? T_RST_END : T_SLOT;
    endfunction

endpackage

// File: rtl/onewire_tick.sv
// Microsecond time base: prescaler of US_DIV clocks feeding a microsecond counter.
module onewire_tick
    import onewire_pkg::*;
#(
    parameter int US_DIV = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_restart,
    output logic             o_tick,
    output logic [TUS_W-1:0] o_t_us
);

    logic [7:0]       r_pre;
    logic [TUS_W-1:0] r_t_us;

    assign o_tick = (r_pre == 8'(US_DIV - 1));
    assign o_t_us = r_t_us;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pre  <= '0;
            r_t_us <= '0;
        end else if (i_restart) begin
            r_pre  <= '0;
            r_t_us <= '0;
        end else if (o_tick) begin
            r_pre  <= '0;
            r_t_us <= r_t_us + 10'd1;
        end else begin
            r_pre  <= r_pre + 8'd1;
        end
    end

endmodule

// File: rtl/onewire_master.sv
// 1-Wire bit master: turns reset/write/read commands into timed bus slots with one response each.
module onewire_master
    import onewire_pkg::*;
#(
    parameter int US_DIV = 12,
    parameter int SYNC_N = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    input  logic [1:0] i_cmd,
    output logic       o_cmd_ready,
    output logic       o_rsp_valid,
    output logic       o_rsp_bit,
    output logic       o_rsp_err,
    output logic       o_busy,
    input  logic       i_owr,
    output logic       o_owr
);

    state_t           r_state;
    logic [1:0]       r_cmd;
    logic [SYNC_N-1:0] r_sync;
    logic [2:0]       r_settle;
    logic             r_ready;
    logic             r_rsp_valid;
    logic             r_rsp_bit;
    logic             r_rsp_err;
    logic             r_owr;

    logic             w_bus_s;
    logic             w_accept;
    logic             w_tick;
    logic [TUS_W-1:0] w_t_us;
    logic [TUS_W-1:0] w_t_next;

    assign w_bus_s  = r_sync[SYNC_N-1];
    assign w_accept = i_cmd_valid && r_ready && (r_state == ST_IDLE);
    // Phase limits are compared against the value t_us takes at this edge,
    // so every phase ends on an exact multiple of US_DIV cycles.
    assign w_t_next = w_t_us + {{(TUS_W-1){1'b0}}, w_tick};

    assign o_cmd_ready = r_ready;
    assign o_busy      = ~r_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_bit   = r_rsp_bit;
    assign o_rsp_err   = r_rsp_err;
    assign o_owr       = r_owr;

    onewire_tick #(
        .US_DIV (US_DIV)
    ) u_tick (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (w_accept),
        .o_tick    (w_tick),
        .o_t_us    (w_t_us)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], i_owr};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= CMD_RESET;
            r_settle    <= '0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_bit   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_owr       <= 1'b1;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if (!w_bus_s) begin
                            r_state     <= ST_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_bit   <= 1'b0;
                        end else begin
                            r_state <= ST_LOW;
                            r_cmd   <= i_cmd;
                            r_owr   <= 1'b0;
                        end
                    end
                end
                ST_LOW: begin
                    if (w_t_next >= low_us(r_cmd)) begin
                        r_owr    <= 1'b1;
                        r_settle <= '0;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_settle < 3'(SYNC_N)) begin
                        r_settle <= r_settle + 3'd1;
                    end
                    // The release must reach bus_s before a sample is trusted,
                    // which matters when the sample point lies inside the low phase.
                    if ((r_settle >= 3'(SYNC_N)) && (w_t_next >= smp_us(r_cmd))) begin
                        r_rsp_bit <= (r_cmd == CMD_RESET) ? ~w_bus_s : w_bus_s;
                        r_state   <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    if (w_t_next >= end_us(r_cmd)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_owr   <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master with US_DIV = 4, SYNC_N = 2 and a simple device model.
module tb_onewire_master;

    localparam logic [1:0] C_RST  = 2'b00;
    localparam logic [1:0] C_W0   = 2'b01;
    localparam logic [1:0] C_W1   = 2'b10;
    localparam logic [1:0] C_READ = 2'b11;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_cmd_valid;
    logic [1:0] i_cmd;
    logic       o_cmd_ready;
    logic       o_rsp_valid;
    logic       o_rsp_bit;
    logic       o_rsp_err;
    logic       o_busy;
    logic       o_owr;
    logic       owr_pad;

    logic stuck  = 1'b0;
    logic dev_en = 1'b0;
    int   dev_s  = 0;
    int   dev_e  = 0;

    int cyc     = 0;
    int acc_cyc = 0;
    int acc_cnt = 0;
    int rsp_cyc = 0;
    int rsp_cnt = 0;
    int low_cnt = 0;
    logic rsp_bit_q = 1'b0;
    logic rsp_err_q = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    onewire_master #(
        .US_DIV (4),
        .SYNC_N (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd       (i_cmd),
        .o_cmd_ready (o_cmd_ready),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_bit   (o_rsp_bit),
        .o_rsp_err   (o_rsp_err),
        .o_busy      (o_busy),
        .i_owr       (owr_pad),
        .o_owr       (o_owr)
    );

    always #5 clk = ~clk;

    // Wired-AND bus: master, a stuck-low fault and a device pulling low in a window after acceptance.
    assign owr_pad = o_owr & ~stuck &
                     ~(dev_en & ((cyc - acc_cyc) >= dev_s) & ((cyc - acc_cyc) < dev_e));

    always @(negedge clk) begin
        if (i_cmd_valid && o_cmd_ready && i_rst) begin
            acc_cyc = cyc;
            acc_cnt = acc_cnt + 1;
        end
        if (!o_owr) low_cnt = low_cnt + 1;
        if (o_rsp_valid) begin
            rsp_cyc   = cyc;
            rsp_bit_q = o_rsp_bit;
            rsp_err_q = o_rsp_err;
            rsp_cnt   = rsp_cnt + 1;
        end
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_acc(input string tag, input int target);
        int n = 0;
        while (acc_cnt < target && n < 8000) begin
            @(posedge clk); #1;
            n++;
        end
        if (acc_cnt < target) check({tag, "_acc_timeout"}, acc_cnt, target);
    endtask

    task automatic wait_rsp(input string tag, input int target);
        int n = 0;
        while (rsp_cnt < target && n < 8000) begin
            @(posedge clk); #1;
            n++;
        end
        if (rsp_cnt < target) check({tag, "_rsp_timeout"}, rsp_cnt, target);
    endtask

    task automatic run_slot(input string tag, input logic [1:0] c, input int exp_low,
                            input int exp_lat, input logic exp_bit);
        int ab, rb, lb;
        @(posedge clk); #1;
        ab = acc_cnt; rb = rsp_cnt; lb = low_cnt;
        i_cmd = c; i_cmd_valid = 1'b1;
        wait_acc(tag, ab + 1);
        i_cmd_valid = 1'b0;
        check({tag, "_busy"}, int'(o_busy), 1);
        wait_rsp(tag, rb + 1);
        check({tag, "_lat"}, rsp_cyc - acc_cyc, exp_lat);
        check({tag, "_low"}, low_cnt - lb, exp_low);
        check({tag, "_bit"}, int'(rsp_bit_q), int'(exp_bit));
        check({tag, "_err"}, int'(rsp_err_q), 0);
        check({tag, "_ready"}, int'(o_cmd_ready), 1);
    endtask

    initial begin
        int ab, rb, lb, acc1, rsp1;
        i_rst = 1'b0; i_cmd_valid = 1'b0; i_cmd = C_RST;
        repeat (3) @(posedge clk);
        #1;
        check("rst_owr", int'(o_owr), 1);
        check("rst_ready", int'(o_cmd_ready), 1);
        check("rst_busy", int'(o_busy), 0);
        check("rst_rspv", int'(o_rsp_valid), 0);
        check("rst_bit", int'(o_rsp_bit), 0);
        check("rst_err", int'(o_rsp_err), 0);
        i_rst = 1'b1;
        repeat (4) @(posedge clk);

        // Presence pulse 30..150 us after release at 480 us
        dev_en = 1'b1; dev_s = 2040; dev_e = 2520;
        run_slot("reset_dev", C_RST, 1920, 3841, 1'b1);
        dev_en = 1'b0;
        run_slot("reset_nodev", C_RST, 1920, 3841, 1'b0);

        run_slot("w1", C_W1, 24, 281, 1'b1);
        run_slot("w0", C_W0, 240, 281, 1'b1);

        dev_en = 1'b1; dev_s = 1; dev_e = 120;
        run_slot("read_dev", C_READ, 24, 281, 1'b0);
        dev_en = 1'b0;
        run_slot("read_idle", C_READ, 24, 281, 1'b1);

        // Stuck-low bus
        stuck = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        ab = acc_cnt; rb = rsp_cnt; lb = low_cnt;
        i_cmd = C_READ; i_cmd_valid = 1'b1;
        wait_acc("stuck", ab + 1);
        i_cmd_valid = 1'b0;
        wait_rsp("stuck", rb + 1);
        check("stuck_lat", rsp_cyc - acc_cyc, 1);
        check("stuck_err", int'(rsp_err_q), 1);
        check("stuck_bit", int'(rsp_bit_q), 0);
        check("stuck_ready", int'(o_cmd_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        check("stuck_low", low_cnt - lb, 0);
        stuck = 1'b0;
        repeat (4) @(posedge clk);

        // Valid held high; command changes mid-slot
        #1;
        ab = acc_cnt; rb = rsp_cnt;
        i_cmd = C_W1; i_cmd_valid = 1'b1;
        wait_acc("hold", ab + 1);
        acc1 = acc_cyc;
        repeat (100) @(posedge clk);
        #1;
        i_cmd = C_READ;
        check("hold_one_acc", acc_cnt, ab + 1);
        wait_rsp("hold1", rb + 1);
        rsp1 = rsp_cyc;
        check("hold1_lat", rsp1 - acc1, 281);
        check("hold1_bit", int'(rsp_bit_q), 1);
        dev_en = 1'b1; dev_s = 1; dev_e = 120;
        wait_acc("hold2", ab + 2);
        i_cmd_valid = 1'b0;
        check("hold2_acc_cyc", acc_cyc, rsp1 + 1);
        wait_rsp("hold2", rb + 2);
        check("hold2_lat", rsp_cyc - acc_cyc, 281);
        check("hold2_bit", int'(rsp_bit_q), 0);
        dev_en = 1'b0;
        repeat (4) @(posedge clk);

        // Reset asserted 100 us into a reset slot
        #1;
        ab = acc_cnt; rb = rsp_cnt;
        i_cmd = C_RST; i_cmd_valid = 1'b1;
        wait_acc("abort", ab + 1);
        i_cmd_valid = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        check("abort_low", int'(o_owr), 0);
        #2 i_rst = 1'b0;
        #1;
        check("abort_owr", int'(o_owr), 1);
        check("abort_ready", int'(o_cmd_ready), 1);
        check("abort_busy", int'(o_busy), 0);
        @(posedge clk); #1;
        i_rst = 1'b1;
        repeat (4000) @(posedge clk);
        #1;
        check("abort_norsp", rsp_cnt, rb);
        check("abort_ready_after", int'(o_cmd_ready), 1);
        check("abort_owr_after", int'(o_owr), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
